microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Microprogrammed control unit for the multicycle MIPS datapath in `top`.
- Holds a registered micro-PC (uPC) that indexes an internal 13-word control store.
- Each cycle it emits the datapath control word for the current micro-instruction, then selects the next uPC in one of four ways: sequential, dispatch-1, dispatch-2 or return-to-fetch.
- Replaces the hard-wired main FSM; `top`'s datapath, memory and ALU decoder are unchanged.

Parameters:
- OP_W, 6, opcode width (Instr[31:26]).
- UPC_W, 4, micro-PC width; must satisfy 2**UPC_W >= 13.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- NRESET  in  1  synchronous, active-high reset.
- Op  in  OP_W  opcode from instruction register.
- Zero  in  1  ALU zero flag.
- Stall  in  1  hold request from memory; freezes sequencing.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- PCEn  out  1  PC load; equals (PCWrite | (Branch & Zero)) after gating.
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut).
- RegDst  out  1  write register select (0 = rt, 1 = rd).
- MemtoReg  out  1  write-back select (0 = ALUOut, 1 = Data).
- ALUSrcA  out  1  ALU A select (0 = PC, 1 = A).
- ALUSrcB  out  2  ALU B select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- ALUOp  out  2  to ALU decoder (00 = add, 01 = sub, 10 = funct).
- PCSrc  out  2  next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- InstrDone  out  1  pulse in the last micro-step of each instruction.
- Illegal  out  1  high while in the ILLEGAL micro-step.
- uPC  out  UPC_W  current micro-address (debug).

Behaviour:
- Reset (NRESET = 1 at a rising edge): uPC <= 0 (FETCH).
  - While NRESET is high, MemWrite, IRWrite, RegWrite, PCEn, InstrDone and Illegal are forced to 0.
  - Mux selects show FETCH values: IorD 0, ALUSrcA 0, ALUSrcB 01, ALUOp 00, PCSrc 00, RegDst 0, MemtoReg 0.
  - Reset mid-instruction aborts it; no partial write occurs in the reset cycle.
- Outputs are Moore-style: a combinational function of the registered uPC, plus Zero for PCEn. Unlisted signals in each micro-word below are 0.
- Control store: address, name, active fields, next-address control.
  - 0 FETCH: IRWrite, PCWrite, ALUSrcB = 01; next.
  - 1 DECODE: ALUSrcB = 11; dispatch-1.
  - 2 MEMADR: ALUSrcA, ALUSrcB = 10; dispatch-2.
  - 3 MEMRD: IorD; next.
  - 4 MEMWB: RegWrite, MemtoReg; fetch.
  - 5 MEMWR: IorD, MemWrite; fetch.
  - 6 EXECUTE: ALUSrcA, ALUOp = 10; next.
  - 7 ALUWB: RegDst, RegWrite; fetch.
  - 8 BRANCH: ALUSrcA, ALUOp = 01, PCSrc = 01, Branch; fetch.
  - 9 ADDIEX: ALUSrcA, ALUSrcB = 10; next.
  - 10 ADDIWB: RegWrite; fetch.
  - 11 JUMP: PCSrc = 10, PCWrite; fetch.
  - 12 ILLEGAL: Illegal; fetch.
- Dispatch-1 (from DECODE):
  - Op 100011 (lw) / 101011 (sw) -> 2.
  - Op 000000 (R-type) -> 6.
  - Op 000100 (beq) -> 8.
  - Op 001000 (addi) -> 9.
  - Op 000010 (j) -> 11.
  - Any other Op -> 12.
- Dispatch-2 (from MEMADR): 100011 -> 3, 101011 -> 5, anything else -> 12 (defensive).
- Next-address modes: next = uPC+1; fetch = 0. uPC values 13..15 are unreachable; if entered, they behave as ILLEGAL.
- InstrDone = 1 in any micro-step whose next-address control is fetch, provided Stall = 0.
- Stall = 1:
  - uPC holds.
  - MemWrite, IRWrite, RegWrite, PCEn and InstrDone are forced to 0; Illegal is not gated.
  - Mux selects are unchanged.
  - Stall in DECODE holds the step; dispatch uses Op in the first non-stalled DECODE cycle.
- Reset has priority over Stall.
- Latency in cycles, FETCH inclusive, no stall: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 3.
- Branch taken iff Zero = 1 during BRANCH; Zero is sampled only there.

Test Plan:
- Reset: hold NRESET = 1 for 2 cycles, then release -> uPC = 0, all enables 0 during reset; first cycle after release shows IRWrite = 1, PCEn = 1.
- lw (Op = 100011): uPC sequence 0, 1, 2, 3, 4, 0 -> RegWrite = 1, MemtoReg = 1 only at uPC 4; InstrDone only at uPC 4.
- sw (Op = 101011) within the `top` program -> MemWrite = 1 exactly one cycle at uPC 5, with Address = 100 and WriteData = 7; MemWrite = 0 in every other cycle.
- beq: Op = 000100 with Zero = 1 -> PCEn = 1 at uPC 8; repeat with Zero = 0 -> PCEn = 0 at uPC 8; both return to uPC 0 the next cycle.
- Stall: assert Stall for 3 cycles at uPC 5 (sw) -> uPC stays 5, MemWrite = 0 for those 3 cycles, then MemWrite = 1 for exactly 1 cycle after release.
- Illegal and reset mid-operation: Op = 111111 -> uPC 0, 1, 12, 0 with Illegal = 1 for one cycle; separately, assert NRESET at uPC 9 -> uPC = 0 next cycle, no RegWrite pulse.

Source files
------------

// File: rtl/microsequencer.sv
// Microprogrammed control unit for the multicycle MIPS datapath.
// A registered micro-PC indexes a 13-word control store. Each micro-word
// supplies the datapath control fields and a next-address mode: sequential,
// dispatch-1, dispatch-2 or return-to-fetch. Outputs are Moore-style; they
// depend on the registered micro-PC, plus Zero for PCEn. During reset and
// stall cycles the write enables are suppressed.
module microsequencer #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned UPC_W = 4
) (
  input  logic             CLK,
  input  logic             NRESET,
  input  logic [OP_W-1:0]  Op,
  input  logic             Zero,
  input  logic             Stall,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             PCEn,
  output logic             IorD,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             InstrDone,
  output logic             Illegal,
  output logic [UPC_W-1:0] uPC
);

  // Next-address control carried in each micro-word
  typedef enum logic [1:0] {
    NaNext  = 2'd0,
    NaDisp1 = 2'd1,
    NaDisp2 = 2'd2,
    NaFetch = 2'd3
  } next_mode_e;

  // Control-store addresses
  localparam logic [UPC_W-1:0] UA_FETCH   = UPC_W'(0);
  localparam logic [UPC_W-1:0] UA_DECODE  = UPC_W'(1);
  localparam logic [UPC_W-1:0] UA_MEMADR  = UPC_W'(2);
  localparam logic [UPC_W-1:0] UA_MEMRD   = UPC_W'(3);
  localparam logic [UPC_W-1:0] UA_MEMWB   = UPC_W'(4);
  localparam logic [UPC_W-1:0] UA_MEMWR   = UPC_W'(5);
  localparam logic [UPC_W-1:0] UA_EXECUTE = UPC_W'(6);
  localparam logic [UPC_W-1:0] UA_ALUWB   = UPC_W'(7);
  localparam logic [UPC_W-1:0] UA_BRANCH  = UPC_W'(8);
  localparam logic [UPC_W-1:0] UA_ADDIEX  = UPC_W'(9);
  localparam logic [UPC_W-1:0] UA_ADDIWB  = UPC_W'(10);
  localparam logic [UPC_W-1:0] UA_JUMP    = UPC_W'(11);
  localparam logic [UPC_W-1:0] UA_ILLEGAL = UPC_W'(12);

  // Opcodes recognised by the dispatch tables
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  logic [UPC_W-1:0] r_upc;

  // Decoded micro-word fields
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_iord;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;
  logic       w_illegal;
  next_mode_e w_mode;

  logic [UPC_W-1:0] w_disp1;
  logic [UPC_W-1:0] w_disp2;
  logic [UPC_W-1:0] w_upc_next;

  // Control store: micro-word lookup for the current micro-PC
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_illegal  = 1'b0;
    w_mode     = NaFetch;
    case (r_upc)
      UA_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_mode    = NaNext;
      end
      UA_DECODE: begin
        w_alusrcb = 2'b11;
        w_mode    = NaDisp1;
      end
      UA_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_mode    = NaDisp2;
      end
      UA_MEMRD: begin
        w_iord = 1'b1;
        w_mode = NaNext;
      end
      UA_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      UA_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      UA_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_mode    = NaNext;
      end
      UA_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      UA_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      UA_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_mode    = NaNext;
      end
      UA_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      UA_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      // ILLEGAL, and the unreachable addresses 13..15 which alias to it
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Dispatch-1 table, consulted from DECODE
  always_comb begin
    case (Op)
      OP_LW, OP_SW: w_disp1 = UA_MEMADR;
      OP_RTYPE:     w_disp1 = UA_EXECUTE;
      OP_BEQ:       w_disp1 = UA_BRANCH;
      OP_ADDI:      w_disp1 = UA_ADDIEX;
      OP_J:         w_disp1 = UA_JUMP;
      default:      w_disp1 = UA_ILLEGAL;
    endcase
  end

  // Dispatch-2 table, consulted from MEMADR; non-memory ops trap defensively
  always_comb begin
    case (Op)
      OP_LW:   w_disp2 = UA_MEMRD;
      OP_SW:   w_disp2 = UA_MEMWR;
      default: w_disp2 = UA_ILLEGAL;
    endcase
  end

  // Next micro-address selection
  always_comb begin
    w_upc_next = UA_FETCH;
    case (w_mode)
      NaNext:  w_upc_next = r_upc + UPC_W'(1);
      NaDisp1: w_upc_next = w_disp1;
      NaDisp2: w_upc_next = w_disp2;
      default: w_upc_next = UA_FETCH;
    endcase
  end

  // Micro-PC register; reset wins over stall, stall freezes sequencing
  always_ff @(posedge CLK) begin
    if (NRESET) begin
      r_upc <= UA_FETCH;
    end else if (!Stall) begin
      r_upc <= w_upc_next;
    end
  end

  // Output gating: reset forces FETCH selects and kills all enables;
  // stall kills state-changing enables but leaves selects and Illegal alone
  always_comb begin
    if (NRESET) begin
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      PCEn      = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
      IorD      = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b01;
      ALUOp     = 2'b00;
      PCSrc     = 2'b00;
    end else begin
      MemWrite  = w_memwrite & ~Stall;
      IRWrite   = w_irwrite & ~Stall;
      RegWrite  = w_regwrite & ~Stall;
      PCEn      = (w_pcwrite | (w_branch & Zero)) & ~Stall;
      InstrDone = (w_mode == NaFetch) & ~Stall;
      Illegal   = w_illegal;
      IorD      = w_iord;
      RegDst    = w_regdst;
      MemtoReg  = w_memtoreg;
      ALUSrcA   = w_alusrca;
      ALUSrcB   = w_alusrcb;
      ALUOp     = w_aluop;
      PCSrc     = w_pcsrc;
    end
  end

  assign uPC = r_upc;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer. Every cycle compares the micro-PC and a
// packed control vector against hand-computed constants. Vector layout:
// {MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg, ALUSrcA,
//  ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], InstrDone, Illegal}
module tb_microsequencer;

  logic       CLK = 1'b0;
  logic       NRESET;
  logic [5:0] Op;
  logic       Zero;
  logic       Stall;
  logic       MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       InstrDone, Illegal;
  logic [3:0] uPC;

  int n_vec = 0;
  int n_err = 0;

  // Expected control vectors, worked out by hand from the micro-word table
  localparam logic [15:0] W_RESET   = 16'h0040;
  localparam logic [15:0] W_FETCH   = 16'h5040;
  localparam logic [15:0] W_DECODE  = 16'h00C0;
  localparam logic [15:0] W_MEMADR  = 16'h0180;
  localparam logic [15:0] W_MEMRD   = 16'h0800;
  localparam logic [15:0] W_MEMWB   = 16'h2202;
  localparam logic [15:0] W_MEMWR   = 16'h8802;
  localparam logic [15:0] W_MEMWR_S = 16'h0800;
  localparam logic [15:0] W_EXEC    = 16'h0120;
  localparam logic [15:0] W_ALUWB   = 16'h2402;
  localparam logic [15:0] W_BEQ_T   = 16'h1116;
  localparam logic [15:0] W_BEQ_N   = 16'h0116;
  localparam logic [15:0] W_ADDIEX  = 16'h0180;
  localparam logic [15:0] W_ADDIWB  = 16'h2002;
  localparam logic [15:0] W_JUMP    = 16'h100A;
  localparam logic [15:0] W_ILL     = 16'h0003;
  localparam logic [15:0] W_ILL_S   = 16'h0001;

  microsequencer #(.OP_W(6), .UPC_W(4)) dut (
    .CLK       (CLK),
    .NRESET    (NRESET),
    .Op        (Op),
    .Zero      (Zero),
    .Stall     (Stall),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .PCEn      (PCEn),
    .IorD      (IorD),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .InstrDone (InstrDone),
    .Illegal   (Illegal),
    .uPC       (uPC)
  );

  always #5 CLK = ~CLK;

  logic [15:0] ctl;
  assign ctl = {MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, InstrDone, Illegal};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Compare micro-PC and control vector as they stand now
  task automatic expect_step(input string tag, input logic [3:0] upc, input logic [15:0] w);
    #1;
    check({tag, ".upc"}, {12'd0, uPC}, {12'd0, upc});
    check({tag, ".ctl"}, ctl, w);
  endtask

  // Advance one clock; sampling happens 1-2 time units after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    NRESET = 1'b1;
    Op     = 6'b000000;
    Zero   = 1'b0;
    Stall  = 1'b0;

    // Reset held for two cycles
    tick(); expect_step("rst0", 4'd0, W_RESET);
    tick(); expect_step("rst1", 4'd0, W_RESET);
    NRESET = 1'b0;
    expect_step("rel", 4'd0, W_FETCH);

    // lw: 0,1,2,3,4,0
    Op = 6'b100011;
    tick(); expect_step("lw.dec", 4'd1, W_DECODE);
    tick(); expect_step("lw.adr", 4'd2, W_MEMADR);
    tick(); expect_step("lw.rd",  4'd3, W_MEMRD);
    tick(); expect_step("lw.wb",  4'd4, W_MEMWB);
    tick(); expect_step("lw.end", 4'd0, W_FETCH);

    // sw with 3-cycle stall at MEMWR
    Op = 6'b101011;
    tick(); expect_step("sw.dec", 4'd1, W_DECODE);
    tick(); expect_step("sw.adr", 4'd2, W_MEMADR);
    tick(); Stall = 1'b1; expect_step("sw.st0", 4'd5, W_MEMWR_S);
    tick(); expect_step("sw.st1", 4'd5, W_MEMWR_S);
    tick(); expect_step("sw.st2", 4'd5, W_MEMWR_S);
    tick(); Stall = 1'b0; expect_step("sw.wr", 4'd5, W_MEMWR);
    tick(); expect_step("sw.end", 4'd0, W_FETCH);

    // beq taken, then not taken
    Op = 6'b000100; Zero = 1'b1;
    tick(); expect_step("beqt.dec", 4'd1, W_DECODE);
    tick(); expect_step("beqt.br",  4'd8, W_BEQ_T);
    tick(); expect_step("beqt.end", 4'd0, W_FETCH);
    Zero = 1'b0;
    tick(); expect_step("beqn.dec", 4'd1, W_DECODE);
    tick(); expect_step("beqn.br",  4'd8, W_BEQ_N);
    tick(); expect_step("beqn.end", 4'd0, W_FETCH);

    // R-type
    Op = 6'b000000;
    tick(); expect_step("r.dec", 4'd1, W_DECODE);
    tick(); expect_step("r.ex",  4'd6, W_EXEC);
    tick(); expect_step("r.wb",  4'd7, W_ALUWB);
    tick(); expect_step("r.end", 4'd0, W_FETCH);

    // j
    Op = 6'b000010;
    tick(); expect_step("j.dec", 4'd1, W_DECODE);
    tick(); expect_step("j.j",   4'd11, W_JUMP);
    tick(); expect_step("j.end", 4'd0, W_FETCH);

    // Illegal opcode; Illegal stays visible under stall, InstrDone does not
    Op = 6'b111111;
    tick(); expect_step("ill.dec", 4'd1, W_DECODE);
    tick(); Stall = 1'b1; expect_step("ill.st", 4'd12, W_ILL_S);
    Stall = 1'b0; expect_step("ill.ill", 4'd12, W_ILL);
    tick(); expect_step("ill.end", 4'd0, W_FETCH);

    // Stall in DECODE: dispatch takes Op from the first unstalled cycle
    tick(); Stall = 1'b1; expect_step("dst.dec", 4'd1, W_DECODE);
    tick(); expect_step("dst.hold", 4'd1, W_DECODE);
    Op = 6'b001000; Stall = 1'b0;
    tick(); expect_step("addi.ex", 4'd9, W_ADDIEX);

    // Reset mid-instruction at ADDIEX, with stall also asserted
    NRESET = 1'b1; Stall = 1'b1;
    expect_step("mrst.now", 4'd9, W_RESET);
    tick(); expect_step("mrst.nxt", 4'd0, W_RESET);
    NRESET = 1'b0; Stall = 1'b0;
    expect_step("mrst.rel", 4'd0, W_FETCH);

    // Full addi after reset
    tick(); expect_step("addi2.dec", 4'd1, W_DECODE);
    tick(); expect_step("addi2.ex",  4'd9, W_ADDIEX);
    tick(); expect_step("addi2.wb",  4'd10, W_ADDIWB);
    tick(); expect_step("addi2.end", 4'd0, W_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
